hps_row_fetch_ctrl: RTL and testbench
=====================================

Name: hps_row_fetch_ctrl

Overview:
Sequences reads of the binarised grey frame from one SDRAM controller read FIFO port on behalf of the HPS.
- Thresholds each pixel, packs 32 pixels per word into a one-row bit buffer, and serves words to the HPS over a 4-phase req/ack handshake.
- Replaces the HPS-toggled read clock and the free-running read port.
- Sits between Sdram_Control_4Port (RDx_* side) and the mysystem PIO exports.

Parameters:
- IMG_W, 640, pixels per row; must be a multiple of WORD_W.
- ROWS, 480, rows per frame.
- WORD_W, 32, bits per packed word.
- RD_LAT, 1, cycles from oRD high to iRD_DATA valid (≥1).
- Derived constants: WPR = IMG_W/WORD_W (20); RW = clog2(ROWS) (9); AW = clog2(WPR) (5).

Ports:
- iCLK, in, 1: single clock; all logic on its rising edge.
- iRST, in, 1: asynchronous, active-high reset.
- iFRAME_START, in, 1: one-cycle pulse; begin a new frame.
- iTHRESH, in, 8: pixel threshold.
- iROW_REQ, in, 1: HPS row request level.
- oROW_ACK, out, 1: row-ready level.
- oLOAD, out, 1: one-cycle pulse to RDx_LOAD (address reload).
- oRD, out, 1: FIFO read strobe.
- iRD_EMPTY, in, 1: FIFO empty.
- iRD_DATA, in, 16: FIFO data; bits [7:0] are grey.
- iWORD_ADDR, in, AW: HPS word select.
- oWORD_DATA, out, WORD_W: registered buffer word.
- oROW_IDX, out, RW: row currently held or being fetched.
- oBUSY, out, 1: high in LOAD, FETCH or DRAIN.
- oFRAME_DONE, out, 1: all ROWS rows delivered.
- oSTATE, out, 3: FSM encoding for LEDR debug.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; counters = 0; buffer contents undefined.
- FSM states and transitions:
  - IDLE -> LOAD on iFRAME_START.
  - LOAD: oLOAD=1 for exactly 1 cycle; row=0; -> WAIT_REQ.
  - WAIT_REQ -> FETCH when iROW_REQ=1 and oROW_ACK=0.
  - FETCH: oRD=1 whenever !iRD_EMPTY and issued<IMG_W. A read-valid shift register delays oRD by RD_LAT cycles. Each valid return writes bit (iRD_DATA[7:0] > iTHRESH, strict) at word x/WORD_W, bit x%WORD_W, with x = received count. When received==IMG_W -> ACK.
  - ACK: oROW_ACK=1; buffer stable. On iROW_REQ=0: oROW_ACK=0 the next cycle; if row==ROWS-1 -> DONE, else row+1 and -> WAIT_REQ.
  - DONE: oFRAME_DONE=1; iROW_REQ ignored; iFRAME_START -> LOAD (oFRAME_DONE clears).
- Buffer is cleared to 0 when FETCH is entered; only 1-bits are written, so bits for skipped pixels are never stale.
- Word read port: oWORD_DATA = buf[iWORD_ADDR] registered, latency 1, in all states. Address ≥ WPR returns 0. Reads during FETCH return partial data (no protection).
- iFRAME_START in WAIT_REQ or ACK: -> LOAD immediately; oROW_ACK drops.
- iFRAME_START in FETCH: -> DRAIN. oRD=0; wait RD_LAT cycles; in-flight returns are discarded; then -> LOAD.
- iFRAME_START in DRAIN or LOAD: ignored.
- iRD_EMPTY high mid-row: oRD stalls; no timeout. Fetch resumes when empty deasserts.
- iROW_REQ already high on re-entering WAIT_REQ after ACK: impossible, since the req=0 edge is required to leave ACK.
- iTHRESH is sampled live per pixel and must be held stable by the user during FETCH.
- iRST mid-operation: immediate return to IDLE, all outputs 0. The SDRAM side is not reloaded until the next LOAD.
- Counters:
  - issued and received: clog2(IMG_W+1) bits, saturating at IMG_W.
  - row: RW bits; no wrap, stops at ROWS-1.

Decomposition:
- Shared package hps_fetch_pkg holds:
  - state enum: IDLE=0, LOAD=1, WAIT_REQ=2, FETCH=3, ACK=4, DRAIN=5, DONE=6 (also drives oSTATE);
  - functions for WPR, AW, RW;
  - the threshold-compare function.
- Sub-module row_bit_buffer: WPR×WORD_W register file.
  - Synchronous clear.
  - Single-bit set port (word address, bit index).
  - Registered read port with out-of-range→0.

Test Plan:
- Reset, pulse iFRAME_START, iRD_EMPTY=0, data ramp (x mod 256), iTHRESH=127, req=1 -> oLOAD one cycle; exactly 640 oRD; ACK. Word 0 = 0x00000000, word 4 (x 128..159) = 0xFFFFFFFF, word 7 (x 224..255) = 0xFFFFFFFF, word 8 (x 256..287) = 0x00000000.
- Constant data 0x0080 with iTHRESH=0x80 -> all 20 words 0 (strict compare). Same data with iTHRESH=0x7F -> all words 0xFFFFFFFF.
- Toggle iRD_EMPTY every 3 cycles during FETCH -> no oRD while empty; still exactly 640 bits written; result matches the unstalled run.
- Run 480 req/ack cycles with ROWS=480 -> oROW_IDX 0..479. oFRAME_DONE rises after the last req drop. A further req produces no ACK. iFRAME_START restarts at row 0.
- iFRAME_START at pixel 300 of a fetch with RD_LAT=3 -> oRD drops next cycle; DRAIN lasts 3 cycles; then an oLOAD pulse; row resets to 0; no buffer write from drained data.
- iRST asserted asynchronously during ACK -> all outputs 0 before the next edge; FSM = IDLE; iWORD_ADDR=25 afterwards returns 0.

Source files
------------

// File: rtl/hps_row_fetch_ctrl_pkg.sv
// Shared state encoding, geometry helpers and the pixel threshold rule
// for the HPS row fetch controller.
package hps_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_REQ = 3'd2,
    ST_FETCH    = 3'd3,
    ST_ACK      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_DONE     = 3'd6
  } fetch_state_e;

  function automatic int calc_wpr(input int img_w, input int word_w);
    return img_w / word_w;
  endfunction

  function automatic int calc_aw(input int wpr);
    return (wpr > 1) ? $clog2(wpr) : 1;
  endfunction

  function automatic int calc_rw(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // A pixel is foreground only when strictly brighter than the threshold.
  function automatic logic pix_above(input logic [7:0] grey, input logic [7:0] thresh);
    return grey > thresh;
  endfunction

endpackage

// File: rtl/hps_row_fetch_ctrl_if.sv
// HPS row handshake, word read port and SDRAM read-FIFO port of the
// row fetch controller.
interface hps_row_fetch_ctrl_if #(
  parameter int AW     = 5,
  parameter int WORD_W = 32
);
  // Row handshake is 4-phase: HPS raises iROW_REQ, controller raises
  // oROW_ACK once the row is buffered, HPS drops req, controller drops ack.
  // FIFO side: oRD pops one entry when iRD_EMPTY is low; data follows RD_LAT later.
  logic              iROW_REQ;
  logic              oROW_ACK;
  logic [AW-1:0]     iWORD_ADDR;
  logic [WORD_W-1:0] oWORD_DATA;
  logic              oLOAD;
  logic              oRD;
  logic              iRD_EMPTY;
  logic [15:0]       iRD_DATA;

  modport master (
    input  iROW_REQ, iWORD_ADDR, iRD_EMPTY, iRD_DATA,
    output oROW_ACK, oWORD_DATA, oLOAD, oRD
  );

  modport slave (
    output iROW_REQ, iWORD_ADDR, iRD_EMPTY, iRD_DATA,
    input  oROW_ACK, oWORD_DATA, oLOAD, oRD
  );
endinterface

// File: rtl/hps_row_fetch_ctrl_row_bit_buffer.sv
// One-row bit buffer: bulk clear, single-bit set, registered word read
// that returns zero for addresses past the end of the row.
module row_bit_buffer #(
  parameter int WPR    = 20,
  parameter int WORD_W = 32,
  parameter int AW     = 5,
  parameter int BW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_word,
  input  logic [BW-1:0]     set_bit,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [WPR];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < WPR; i++) mem[i] <= '0;
    end else if (set_en && (int'(set_word) < WPR)) begin
      mem[set_word][set_bit] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < WPR) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/hps_row_fetch_ctrl.sv
// Fetches one thresholded grey row at a time from the SDRAM read FIFO into
// a packed bit buffer and hands it to the HPS over a req/ack handshake.
module hps_row_fetch_ctrl
  import hps_fetch_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int ROWS   = 480,
  parameter int WORD_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iFRAME_START,
  input  logic [7:0]                iTHRESH,
  hps_row_fetch_ctrl_if.master      bus,
  output logic [calc_rw(ROWS)-1:0]  oROW_IDX,
  output logic                      oBUSY,
  output logic                      oFRAME_DONE,
  output logic [2:0]                oSTATE
);

  localparam int WPR = calc_wpr(IMG_W, WORD_W);
  localparam int AW  = calc_aw(WPR);
  localparam int RW  = calc_rw(ROWS);
  localparam int CW  = $clog2(IMG_W + 1);
  localparam int BW  = $clog2(WORD_W);
  localparam int DW  = $clog2(RD_LAT + 1);

  fetch_state_e      state_q, state_d;
  logic [CW-1:0]     iss_cnt, rcv_cnt;
  logic [RW-1:0]     row_q;
  logic [RD_LAT-1:0] vld_sr;
  logic [DW-1:0]     drain_cnt;
  logic              fetch_start;
  logic              row_inc;
  logic              rd_fire;
  logic              pix_valid;
  logic              unused_data_hi;

  assign unused_data_hi = ^bus.iRD_DATA[15:8];

  assign rd_fire   = (state_q == ST_FETCH) && !bus.iRD_EMPTY && (iss_cnt < CW'(IMG_W));
  // Returns arriving outside FETCH (i.e. while draining) are dropped here.
  assign pix_valid = (state_q == ST_FETCH) && vld_sr[RD_LAT-1] && (rcv_cnt < CW'(IMG_W));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      row_q     <= '0;
      vld_sr    <= '0;
      drain_cnt <= '0;
    end else begin
      state_q <= state_d;
      vld_sr  <= fetch_start ? '0 : ((vld_sr << 1) | RD_LAT'(rd_fire));
      if (fetch_start)    iss_cnt <= '0;
      else if (rd_fire)   iss_cnt <= iss_cnt + 1'b1;
      if (fetch_start)    rcv_cnt <= '0;
      else if (pix_valid) rcv_cnt <= rcv_cnt + 1'b1;
      if (state_q == ST_LOAD) row_q <= '0;
      else if (row_inc)       row_q <= row_q + 1'b1;
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    row_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iFRAME_START) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (iFRAME_START) begin
          state_d = ST_LOAD;
        end else if (bus.iROW_REQ) begin
          state_d     = ST_FETCH;
          fetch_start = 1'b1;
        end
      end
      ST_FETCH: begin
        if (iFRAME_START)              state_d = ST_DRAIN;
        else if (rcv_cnt == CW'(IMG_W)) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (iFRAME_START) begin
          state_d = ST_LOAD;
        end else if (!bus.iROW_REQ) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_REQ;
            row_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DW'(RD_LAT - 1)) state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (iFRAME_START) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.oRD      = rd_fire;
  assign bus.oLOAD    = (state_q == ST_LOAD);
  assign bus.oROW_ACK = (state_q == ST_ACK);
  assign oBUSY        = (state_q == ST_LOAD) || (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign oFRAME_DONE  = (state_q == ST_DONE);
  assign oSTATE       = state_q;
  assign oROW_IDX     = row_q;

  row_bit_buffer #(
    .WPR    (WPR),
    .WORD_W (WORD_W),
    .AW     (AW),
    .BW     (BW)
  ) u_buf (
    .clk      (iCLK),
    .rst      (iRST),
    .clr      (fetch_start),
    .set_en   (pix_valid && pix_above(bus.iRD_DATA[7:0], iTHRESH)),
    .set_word (AW'(rcv_cnt / CW'(WORD_W))),
    .set_bit  (BW'(rcv_cnt % CW'(WORD_W))),
    .rd_addr  (bus.iWORD_ADDR),
    .rd_data  (bus.oWORD_DATA)
  );

endmodule

// File: tb/tb_hps_row_fetch_ctrl.sv
// Bench for hps_row_fetch_ctrl: FIFO responder, randomized rows and stalls,
// and a pixel-list reference model of the packed row buffer.
module tb_hps_row_fetch_ctrl;
  import hps_fetch_pkg::*;

  localparam int IMG_W  = 640;
  localparam int ROWS   = 6;
  localparam int WORD_W = 32;
  localparam int RD_LAT = 3;
  localparam int WPR    = IMG_W / WORD_W;
  localparam int AW     = 5;
  localparam int RW     = 3;

  logic          iCLK;
  logic          iRST;
  logic          iFRAME_START;
  logic [7:0]    iTHRESH;
  logic [RW-1:0] oROW_IDX;
  logic          oBUSY;
  logic          oFRAME_DONE;
  logic [2:0]    oSTATE;

  hps_row_fetch_ctrl_if #(.AW(AW), .WORD_W(WORD_W)) bus ();

  hps_row_fetch_ctrl #(
    .IMG_W  (IMG_W),
    .ROWS   (ROWS),
    .WORD_W (WORD_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iFRAME_START (iFRAME_START),
    .iTHRESH      (iTHRESH),
    .bus          (bus),
    .oROW_IDX     (oROW_IDX),
    .oBUSY        (oBUSY),
    .oFRAME_DONE  (oFRAME_DONE),
    .oSTATE       (oSTATE)
  );

  // clock / reset block
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // stimulus controls and scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          data_mode = 0;
  logic [15:0] const_val = 16'h0000;
  int          stall_mode = 0;
  int          stall_tick = 0;
  int          row_base = 0;
  logic [7:0]  cur_th = 8'h00;
  logic [15:0] pipe [RD_LAT+1];
  logic [15:0] pix_q [$];
  int          rd_count = 0;
  int          rd_while_empty = 0;
  int          load_count = 0;
  int          drain_cycles = 0;
  logic [WORD_W-1:0] last_words [WPR];
  logic [WORD_W-1:0] ramp_words [WPR];

  // SDRAM read FIFO responder: every accepted read returns RD_LAT cycles later
  always @(negedge iCLK) begin
    logic [15:0] gen;
    stall_tick++;
    case (stall_mode)
      1:       bus.iRD_EMPTY = ((stall_tick / 3) % 2) == 1;
      2:       bus.iRD_EMPTY = ($urandom_range(0, 3) == 0);
      default: bus.iRD_EMPTY = 1'b0;
    endcase
    #1;
    for (int i = RD_LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = 16'h00FF;
    if (bus.oRD === 1'b1) begin
      case (data_mode)
        0:       gen = {8'hA5, 8'(pix_q.size() - row_base)};
        1:       gen = const_val;
        default: gen = 16'($urandom);
      endcase
      pipe[0] = gen;
      pix_q.push_back(gen);
      rd_count++;
      if (bus.iRD_EMPTY) rd_while_empty++;
    end
    bus.iRD_DATA = pipe[RD_LAT];
    if (bus.oLOAD === 1'b1) load_count++;
    if (oSTATE == 3'd5) drain_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Reference: bit b of word w is pixel w*WORD_W+b of this row, strictly above threshold
  function automatic logic [WORD_W-1:0] exp_word(input int w);
    logic [WORD_W-1:0] v;
    v = '0;
    for (int b = 0; b < WORD_W; b++) begin
      if (row_base + w * WORD_W + b < pix_q.size())
        v[b] = pix_q[row_base + w * WORD_W + b][7:0] > cur_th;
    end
    return v;
  endfunction

  task automatic read_word(input int addr, output logic [WORD_W-1:0] data);
    bus.iWORD_ADDR = AW'(addr);
    tick(1);
    data = bus.oWORD_DATA;
  endtask

  task automatic pulse_frame_start();
    iFRAME_START = 1'b1;
    tick(1);
    iFRAME_START = 1'b0;
  endtask

  task automatic run_row(input logic [7:0] th, input int mode, input int stall, input int exp_row);
    int t;
    int rd_base;
    int emp_base;
    logic [WORD_W-1:0] got;
    data_mode  = mode;
    stall_mode = stall;
    iTHRESH    = th;
    cur_th     = th;
    row_base   = pix_q.size();
    rd_base    = rd_count;
    emp_base   = rd_while_empty;
    bus.iROW_REQ = 1'b1;
    t = 0;
    while (bus.oROW_ACK !== 1'b1 && t < 5000) begin
      tick(1);
      t++;
    end
    stall_mode = 0;
    check("ack_rise", 32'(bus.oROW_ACK), 32'd1);
    check("rd_per_row", 32'(rd_count - rd_base), 32'(IMG_W));
    check("rd_while_empty", 32'(rd_while_empty - emp_base), 32'd0);
    check("row_idx", 32'(oROW_IDX), 32'(exp_row));
    check("busy_in_ack", 32'(oBUSY), 32'd0);
    for (int w = 0; w < WPR; w++) begin
      read_word(w, got);
      last_words[w] = got;
      check($sformatf("row%0d_word%0d", exp_row, w), got, exp_word(w));
    end
  endtask

  task automatic release_row();
    int t;
    bus.iROW_REQ = 1'b0;
    t = 0;
    while (bus.oROW_ACK !== 1'b0 && t < 100) begin
      tick(1);
      t++;
    end
    check("ack_fall", 32'(bus.oROW_ACK), 32'd0);
  endtask

  initial begin
    int lb;
    int db;
    int rb;
    int t;
    int n_issued;
    int ones;
    logic [WORD_W-1:0] got;

    iRST = 1'b1;
    iFRAME_START = 1'b0;
    iTHRESH = 8'h00;
    bus.iROW_REQ = 1'b0;
    bus.iWORD_ADDR = '0;
    tick(3);
    check("rst_state", 32'(oSTATE), 32'd0);
    check("rst_ack", 32'(bus.oROW_ACK), 32'd0);
    check("rst_load", 32'(bus.oLOAD), 32'd0);
    check("rst_rd", 32'(bus.oRD), 32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_done", 32'(oFRAME_DONE), 32'd0);
    check("rst_row", 32'(oROW_IDX), 32'd0);
    check("rst_word", bus.oWORD_DATA, 32'd0);
    iRST = 1'b0;
    tick(2);

    // frame start: exactly one LOAD pulse, then waiting for a request
    lb = load_count;
    pulse_frame_start();
    tick(3);
    check("load_pulses", 32'(load_count - lb), 32'd1);
    check("state_wait_req", 32'(oSTATE), 32'd2);

    // row 0: grey ramp, threshold 127
    run_row(8'd127, 0, 0, 0);
    for (int w = 0; w < WPR; w++) ramp_words[w] = last_words[w];
    check("ramp_w0", last_words[0], 32'h0000_0000);
    check("ramp_w4", last_words[4], 32'hFFFF_FFFF);
    check("ramp_w7", last_words[7], 32'hFFFF_FFFF);
    check("ramp_w8", last_words[8], 32'h0000_0000);
    release_row();

    // rows 1/2: strict compare at the boundary value
    const_val = 16'h0080;
    run_row(8'h80, 1, 0, 1);
    for (int w = 0; w < WPR; w++) check("eq_thresh_zero", last_words[w], 32'h0000_0000);
    release_row();
    run_row(8'h7F, 1, 0, 2);
    for (int w = 0; w < WPR; w++) check("below_thresh_ones", last_words[w], 32'hFFFF_FFFF);
    release_row();

    // row 3: ramp again with FIFO empty toggling every 3 cycles
    run_row(8'd127, 0, 1, 3);
    for (int w = 0; w < WPR; w++) check("stall_matches_ramp", last_words[w], ramp_words[w]);
    release_row();

    // rows 4/5: random data, threshold and stalls
    run_row(8'($urandom_range(0, 255)), 2, 2, 4);
    release_row();
    run_row(8'($urandom_range(0, 255)), 2, 2, 5);
    release_row();
    tick(1);
    check("frame_done", 32'(oFRAME_DONE), 32'd1);
    check("state_done", 32'(oSTATE), 32'd6);
    check("last_row_idx", 32'(oROW_IDX), 32'(ROWS - 1));

    // requests are ignored once the frame is done
    bus.iROW_REQ = 1'b1;
    tick(20);
    check("no_ack_after_done", 32'(bus.oROW_ACK), 32'd0);
    check("done_held", 32'(oFRAME_DONE), 32'd1);
    bus.iROW_REQ = 1'b0;
    tick(2);

    // restart from DONE
    lb = load_count;
    pulse_frame_start();
    tick(3);
    check("restart_load", 32'(load_count - lb), 32'd1);
    check("restart_row0", 32'(oROW_IDX), 32'd0);
    check("restart_done_clr", 32'(oFRAME_DONE), 32'd0);
    check("restart_wait_req", 32'(oSTATE), 32'd2);

    // abort a fetch around pixel 300: drain, reload, discard in-flight data
    data_mode = 1;
    const_val = 16'h00FF;
    iTHRESH = 8'h00;
    cur_th = 8'h00;
    stall_mode = 0;
    row_base = pix_q.size();
    rb = rd_count;
    bus.iROW_REQ = 1'b1;
    t = 0;
    while ((rd_count - rb) < 300 && t < 2000) begin
      tick(1);
      t++;
    end
    check("abort_reached_300", 32'((rd_count - rb) >= 300), 32'd1);
    lb = load_count;
    db = drain_cycles;
    iFRAME_START = 1'b1;
    bus.iROW_REQ = 1'b0;
    tick(1);
    iFRAME_START = 1'b0;
    n_issued = rd_count - rb;
    check("abort_in_drain", 32'(oSTATE), 32'd5);
    check("abort_busy", 32'(oBUSY), 32'd1);
    tick(8);
    check("drain_no_rd", 32'(rd_count - rb), 32'(n_issued));
    check("drain_cycles", 32'(drain_cycles - db), 32'(RD_LAT));
    check("abort_load", 32'(load_count - lb), 32'd1);
    check("abort_row0", 32'(oROW_IDX), 32'd0);
    check("abort_wait_req", 32'(oSTATE), 32'd2);
    ones = 0;
    for (int w = 0; w < WPR; w++) begin
      read_word(w, got);
      ones += $countones(got);
    end
    check("abort_bits_written", 32'(ones), 32'(n_issued - RD_LAT));

    // fresh rows after the abort, then async reset while holding ACK
    run_row(8'd127, 0, 0, 0);
    release_row();
    run_row(8'($urandom_range(0, 255)), 2, 2, 1);
    #2;
    iRST = 1'b1;
    #1;
    check("arst_ack", 32'(bus.oROW_ACK), 32'd0);
    check("arst_state", 32'(oSTATE), 32'd0);
    check("arst_row", 32'(oROW_IDX), 32'd0);
    check("arst_busy", 32'(oBUSY), 32'd0);
    check("arst_done", 32'(oFRAME_DONE), 32'd0);
    check("arst_word", bus.oWORD_DATA, 32'd0);
    check("arst_load", 32'(bus.oLOAD), 32'd0);
    check("arst_rd", 32'(bus.oRD), 32'd0);
    bus.iROW_REQ = 1'b0;
    tick(2);
    iRST = 1'b0;
    read_word(25, got);
    tick(1);
    check("addr25_zero", bus.oWORD_DATA, 32'd0);
    check("idle_after_rst", 32'(oSTATE), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
